alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 35 +++
 rtl/alu_ctrl_alu.sv | 29 ++
 rtl/alu_ctrl.sv | 110 +++++++++++
 tb/tb_alu_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for alu_ctrl: FSM states, ALU op codes, instruction field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_ctrl_pkg;

  // Instruction layout: [9] li, [8:7] op, [6:5] rd, [4] reserved, [3:2] rs1, [1:0] rs2
  localparam int INSTR_W  = 10;
  localparam int LI_BIT   = 9;
  localparam int OP_MSB   = 8;
  localparam int OP_LSB   = 7;
  localparam int RD_MSB   = 6;
  localparam int RD_LSB   = 5;
  localparam int RSVD_BIT = 4;
  localparam int RS1_MSB  = 3;
  localparam int RS1_LSB  = 2;
  localparam int RS2_MSB  = 1;
  localparam int RS2_LSB  = 0;
  // Immediate overlays rs1/rs2 when li=1
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_ADDINC = 2'd1,
    OP_AND    = 2'd2,
    OP_OR     = 2'd3
  } op_t;

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational W-bit ALU: add, add+1, and, or; sums wrap modulo 2**W.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu_ctrl_alu
  import alu_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  op_t          i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Operation select; carries are dropped by the W-bit result width
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:    o_y = i_a + i_b;
      OP_ADDINC: o_y = i_a + i_b + ONE;
      OP_AND:    o_y = i_a & i_b;
      OP_OR:     o_y = i_a | i_b;
      default:   o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// One-at-a-time instruction engine: 4-entry register file + ALU, IDLE -> EXEC -> WB.
// Latency: accepted at edge N, register written and result valid after edge N+1; >= 3 cycles/instr.
// Backpressure: result held in WB until out_ready; in_ready only in IDLE, no input queueing.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W    = 4,
  parameter int NREG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_rd,
  output logic [W-1:0]       out_data
);

  state_t             r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [W-1:0]       r_regs [NREG];
  logic               r_out_valid;
  logic [1:0]         r_out_rd;
  logic [W-1:0]       r_out_data;

  logic               w_li;
  op_t                w_op;
  logic [1:0]         w_rd;
  logic [1:0]         w_rs1;
  logic [1:0]         w_rs2;
  logic [W-1:0]       w_imm;
  logic [W-1:0]       w_a;
  logic [W-1:0]       w_b;
  logic [W-1:0]       w_alu_y;
  logic [W-1:0]       w_result;
  logic               w_unused_rsvd;

  // Field decode of the captured instruction
  assign w_li          = r_instr[LI_BIT];
  assign w_op          = op_t'(r_instr[OP_MSB:OP_LSB]);
  assign w_rd          = r_instr[RD_MSB:RD_LSB];
  assign w_rs1         = r_instr[RS1_MSB:RS1_LSB];
  assign w_rs2         = r_instr[RS2_MSB:RS2_LSB];
  assign w_imm         = r_instr[IMM_MSB:IMM_LSB];
  assign w_unused_rsvd = r_instr[RSVD_BIT];

  // Operands come straight from the register array, so a write to rd in the
  // same EXEC edge never affects this instruction's own sources.
  assign w_a = r_regs[w_rs1];
  assign w_b = r_regs[w_rs2];

  alu_ctrl_alu #(
    .W (W)
  ) u_alu (
    .i_op (w_op),
    .i_a  (w_a),
    .i_b  (w_b),
    .o_y  (w_alu_y)
  );

  // Load-immediate bypasses the ALU and ignores op
  assign w_result = w_li ? w_imm : w_alu_y;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_rd    = r_out_rd;
  assign out_data  = r_out_data;

  // Control FSM, register-file write and registered write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_instr     <= '0;
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_out_data  <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_instr <= in_instr;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_regs[w_rd] <= w_result;
          r_out_rd     <= w_rd;
          r_out_data   <= w_result;
          r_out_valid  <= 1'b1;
          r_state      <= ST_WB;
        end
        ST_WB: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: scoreboard of expected write-backs vs. DUT results.
// Latency: checks one-cycle EXEC and WB hold under backpressure.
// Backpressure: out_ready randomised, with a forced-stall phase.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] in_instr = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_rd;
  logic [3:0] out_data;

  int checks   = 0;
  int failures = 0;

  logic [5:0] sb_q [$];
  int         ref_regs [4];
  int         last_rd;
  int         last_data;
  bit         bp_force = 1'b0;
  bit         bp_val   = 1'b1;

  alu_ctrl #(.W(4), .NREG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk_op(input int op, input int rd, input int rs1, input int rs2);
    return {1'b0, 2'(op), 2'(rd), 1'b0, 2'(rs1), 2'(rs2)};
  endfunction

  // Load immediate with junk in op and reserved bit, which must be ignored
  function automatic logic [9:0] mk_li(input int rd, input int imm);
    return {1'b1, 2'b11, 2'(rd), 1'b1, 4'(imm)};
  endfunction

  // Reference: architectural effect of one instruction on a 4-entry register file
  task automatic model(input logic [9:0] ins);
    int a, b, v;
    a = ref_regs[ins[3:2]];
    b = ref_regs[ins[1:0]];
    if (ins[9]) v = int'(ins[3:0]);
    else begin
      case (ins[8:7])
        2'd0:    v = (a + b) % 16;
        2'd1:    v = (a + b + 1) % 16;
        2'd2:    v = a & b;
        default: v = a | b;
      endcase
    end
    ref_regs[ins[6:5]] = v;
    last_rd   = int'(ins[6:5]);
    last_data = v;
    sb_q.push_back({2'(last_rd), 4'(last_data)});
  endtask

  // Issue one instruction; exp_d >= 0 additionally pins the written value
  task automatic send(input logic [9:0] ins, input int exp_d);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_instr = 10'($urandom);
    model(ins);
    chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    if (exp_d >= 0) chk("directed_data", {28'd0, out_data}, exp_d);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", sb_q.size(), 32'd0);
  endtask

  // Consumer: randomly stalls unless a phase forces out_ready
  initial begin
    forever begin
      @(posedge clk); #3;
      out_ready = bp_force ? bp_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every accepted write-back must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h with nothing expected", out_rd, out_data);
      end else begin
        chk("wb_result", {26'd0, out_rd, out_data}, {26'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) ref_regs[i] = 0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_rd",    {30'd0, out_rd},    32'd0);
    chk("rst_out_data",  {28'd0, out_data},  32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // add r3 = r0 + r1 on a freshly reset file
    send(mk_op(0, 3, 0, 1), 0);

    // Arithmetic
    send(mk_li(1, 5), 5);
    send(mk_li(2, 3), 3);
    send(mk_op(0, 3, 1, 2), 8);
    send(mk_op(1, 0, 1, 2), 9);

    // Wrap modulo 16
    send(mk_li(1, 15), 15);
    send(mk_op(1, 2, 1, 1), 15);
    send(mk_op(0, 2, 1, 1), 14);

    // Logic ops and rd == rs1 reads the old value
    send(mk_li(1, 12), 12);
    send(mk_li(2, 10), 10);
    send(mk_op(2, 3, 1, 2), 8);
    send(mk_op(3, 0, 1, 2), 14);
    send(mk_op(2, 1, 1, 2), 8);
    send(mk_op(3, 2, 1, 2), 10);
    drain();

    // Backpressure: hold result for 5 cycles while new requests are offered
    bp_force = 1'b1;
    bp_val   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(mk_op(0, 3, 1, 2), 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = 10'($urandom);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_rd",    {30'd0, out_rd},    last_rd);
      chk("bp_out_data",  {28'd0, out_data},  last_data);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    bp_val = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_idle",  {31'd0, in_ready},  32'd1);
    chk("bp_hold_data",     {28'd0, out_data},  last_data);
    chk("bp_queue_empty",   sb_q.size(),        32'd0);
    bp_force = 1'b0;

    // Reset during EXEC of li r2=7 abandons it
    in_valid = 1'b1;
    in_instr = mk_li(2, 7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_exec_state", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 0;
    @(posedge clk); #1;
    chk("abort_no_wb", {31'd0, out_valid}, 32'd0);
    send(mk_op(0, 3, 2, 2), 0);
    send(mk_op(3, 1, 2, 0), 0);

    // Random instruction stream with random consumer stalls
    for (int i = 0; i < 60; i++) begin
      send(10'($urandom), -1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
